// File: rtl/adc_pkg.sv
// Shared types and constants for the ADC conversion model: state encoding,
// reset values and a helper that sizes the conversion counter.
package adc_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_CONV = 1'b1
  } adc_state_e;

  localparam adc_state_e RST_STATE   = ST_IDLE;
  localparam logic       RST_BUSY    = 1'b0;
  localparam logic       RST_EOC     = 1'b0;
  localparam logic       RST_OVERRUN = 1'b0;

  // Smallest counter width able to hold conv_cycles-1 (at least one bit).
  function automatic int cnt_width(input int conv_cycles);
    int w;
    w = 1;
    while ((1 << w) < conv_cycles) w++;
    return w;
  endfunction

endpackage

// File: rtl/adc_ch_mux.sv
// Combinational NUM_CH:1 channel selector; a select beyond the last channel
// yields an all-zero sample.
module adc_ch_mux #(
  parameter int WIDTH  = 8,
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2
) (
  input  logic [NUM_CH*WIDTH-1:0] ch_in,
  input  logic [CH_W-1:0]         sel,
  output logic [WIDTH-1:0]        y
);

  always_comb begin
    y = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (sel == CH_W'(i)) y = ch_in[i*WIDTH +: WIDTH];
    end
  end

endmodule

// File: rtl/adc_conv_model.sv
// Multi-channel ADC conversion model: sample-and-hold on start, result after
// CONV_CYCLES clocks, with abort and sticky overrun reporting.
module adc_conv_model
  import adc_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int NUM_CH      = 4,
  parameter int CH_W        = 2,
  parameter int CONV_CYCLES = 8,
  parameter int CNT_W       = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH*WIDTH-1:0] ch_in,
  input  logic                    start,
  input  logic [CH_W-1:0]         ch_sel,
  input  logic                    abort,
  output logic                    busy,
  output logic                    eoc,
  output logic [WIDTH-1:0]        data_out,
  output logic [CH_W-1:0]         data_ch,
  output logic                    overrun
);

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CONV_CYCLES - 1);

  // Handshake: start is accepted only when busy is low and abort is low; busy
  // rises on the edge after acceptance and stays high for CONV_CYCLES edges.
  // eoc is a one-cycle pulse with data_out/data_ch valid in that same cycle,
  // and that cycle may already accept the next start.
  adc_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0]  hold_q, hold_d;
  logic [CH_W-1:0]   hold_ch_q, hold_ch_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic [CH_W-1:0]   data_ch_q, data_ch_d;
  logic              busy_q, busy_d;
  logic              eoc_q, eoc_d;
  logic              ovr_q, ovr_d;
  logic [WIDTH-1:0]  mux_y;

  adc_ch_mux #(
    .WIDTH (WIDTH),
    .NUM_CH(NUM_CH),
    .CH_W  (CH_W)
  ) u_mux (
    .ch_in(ch_in),
    .sel  (ch_sel),
    .y    (mux_y)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hold_d    = hold_q;
    hold_ch_d = hold_ch_q;
    data_d    = data_q;
    data_ch_d = data_ch_q;
    busy_d    = busy_q;
    eoc_d     = 1'b0;
    ovr_d     = ovr_q;
    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          hold_d    = mux_y;
          hold_ch_d = ch_sel;
          cnt_d     = RELOAD;
          state_d   = ST_CONV;
          busy_d    = 1'b1;
          ovr_d     = 1'b0;
        end
      end
      ST_CONV: begin
        // abort outranks both a finishing count and a colliding start
        if (abort) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else begin
          if (start) ovr_d = 1'b1;
          if (cnt_q == '0) begin
            data_d    = hold_q;
            data_ch_d = hold_ch_q;
            eoc_d     = 1'b1;
            busy_d    = 1'b0;
            state_d   = ST_IDLE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= RST_STATE;
      cnt_q     <= '0;
      hold_q    <= '0;
      hold_ch_q <= '0;
      data_q    <= '0;
      data_ch_q <= '0;
      busy_q    <= RST_BUSY;
      eoc_q     <= RST_EOC;
      ovr_q     <= RST_OVERRUN;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hold_q    <= hold_d;
      hold_ch_q <= hold_ch_d;
      data_q    <= data_d;
      data_ch_q <= data_ch_d;
      busy_q    <= busy_d;
      eoc_q     <= eoc_d;
      ovr_q     <= ovr_d;
    end
  end

  assign busy     = busy_q;
  assign eoc      = eoc_q;
  assign data_out = data_q;
  assign data_ch  = data_ch_q;
  assign overrun  = ovr_q;

endmodule

// File: tb/tb_adc_conv_model.sv
// Bench for adc_conv_model: a default 8-bit/4-channel/8-cycle instance and a
// 12-bit/3-channel/1-cycle instance, both checked against an edge-count model.
module tb_adc_conv_model;
  import adc_pkg::*;

  localparam int CONV_A = 8;
  localparam int CONV_B = 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] ch_in_a;
  logic        start_a, abort_a;
  logic [1:0]  ch_sel_a;
  logic        busy_a, eoc_a, ovr_a;
  logic [7:0]  data_out_a;
  logic [1:0]  data_ch_a;

  logic [35:0] ch_in_b;
  logic        start_b, abort_b;
  logic [1:0]  ch_sel_b;
  logic        busy_b, eoc_b, ovr_b;
  logic [11:0] data_out_b;
  logic [1:0]  data_ch_b;

  adc_conv_model #(
    .WIDTH(8), .NUM_CH(4), .CH_W(2), .CONV_CYCLES(CONV_A), .CNT_W(4)
  ) dut_a (
    .clk(clk), .rst(rst), .ch_in(ch_in_a), .start(start_a), .ch_sel(ch_sel_a),
    .abort(abort_a), .busy(busy_a), .eoc(eoc_a), .data_out(data_out_a),
    .data_ch(data_ch_a), .overrun(ovr_a)
  );

  adc_conv_model #(
    .WIDTH(12), .NUM_CH(3), .CH_W(2), .CONV_CYCLES(CONV_B),
    .CNT_W(cnt_width(CONV_B))
  ) dut_b (
    .clk(clk), .rst(rst), .ch_in(ch_in_b), .start(start_b), .ch_sel(ch_sel_b),
    .abort(abort_b), .busy(busy_b), .eoc(eoc_b), .data_out(data_out_b),
    .data_ch(data_ch_b), .overrun(ovr_b)
  );

  // ---------------- scoreboard and reference model ----------------
  int n_checks = 0;
  int n_err    = 0;
  int edge_n   = 0;
  bit mon_en   = 1'b0;

  logic [9:0]  exp_q_a[$];
  logic [13:0] exp_q_b[$];

  bit          m_pend[2];
  int          m_fin[2];
  logic [11:0] m_samp[2];
  logic [1:0]  m_ch[2];
  bit          m_ovr[2];
  logic [11:0] m_data[2];
  logic [1:0]  m_dch[2];
  bit          m_eoc[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", name, edge_n, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_pend[i] = 0; m_fin[i] = 0; m_samp[i] = '0; m_ch[i] = '0;
      m_ovr[i] = 0; m_data[i] = '0; m_dch[i] = '0; m_eoc[i] = 0;
    end
    exp_q_a.delete();
    exp_q_b.delete();
  endtask

  // One clock edge of behaviour: a conversion accepted at edge k finishes at
  // edge k+conv unless aborted first.
  task automatic model_step(input int id, input bit st, input logic [1:0] sel,
                            input bit ab, input logic [11:0] sample);
    int conv;
    conv = (id == 0) ? CONV_A : CONV_B;
    m_eoc[id] = 0;
    if (m_pend[id]) begin
      if (ab) begin
        m_pend[id] = 0;
      end else begin
        if (st) m_ovr[id] = 1;
        if (edge_n == m_fin[id]) begin
          m_pend[id] = 0;
          m_eoc[id]  = 1;
          m_data[id] = m_samp[id];
          m_dch[id]  = m_ch[id];
          if (id == 0) exp_q_a.push_back({m_ch[id], m_samp[id][7:0]});
          else         exp_q_b.push_back({m_ch[id], m_samp[id]});
        end
      end
    end else if (st && !ab) begin
      m_pend[id] = 1;
      m_fin[id]  = edge_n + conv;
      m_samp[id] = sample;
      m_ch[id]   = sel;
      m_ovr[id]  = 0;
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst && mon_en) begin
      check("busy_a", busy_a, m_pend[0]);
      check("eoc_a", eoc_a, m_eoc[0]);
      check("overrun_a", ovr_a, m_ovr[0]);
      check("data_out_a", data_out_a, m_data[0][7:0]);
      check("data_ch_a", data_ch_a, m_dch[0]);
      check("busy_b", busy_b, m_pend[1]);
      check("eoc_b", eoc_b, m_eoc[1]);
      check("overrun_b", ovr_b, m_ovr[1]);
      check("data_out_b", data_out_b, m_data[1]);
      check("data_ch_b", data_ch_b, m_dch[1]);
      if (eoc_a) begin
        if (exp_q_a.size() == 0) check("unexpected_eoc_a", 1, 0);
        else check("result_a", {data_ch_a, data_out_a}, exp_q_a.pop_front());
      end
      if (eoc_b) begin
        if (exp_q_b.size() == 0) check("unexpected_eoc_b", 1, 0);
        else check("result_b", {data_ch_b, data_out_b}, exp_q_b.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    logic [11:0] sb;
    @(posedge clk);
    sb = (ch_sel_b < 2'd3) ? ch_in_b[ch_sel_b*12 +: 12] : 12'h000;
    model_step(0, start_a, ch_sel_a, abort_a, {4'h0, ch_in_a[ch_sel_a*8 +: 8]});
    model_step(1, start_b, ch_sel_b, abort_b, sb);
    edge_n++;
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check_reset_outputs();
    check("rst_busy_a", busy_a, 0);
    check("rst_eoc_a", eoc_a, 0);
    check("rst_data_a", data_out_a, 0);
    check("rst_ch_a", data_ch_a, 0);
    check("rst_ovr_a", ovr_a, 0);
    check("rst_busy_b", busy_b, 0);
    check("rst_data_b", data_out_b, 0);
    check("rst_ovr_b", ovr_b, 0);
  endtask

  // Called at a falling edge; reset is asserted and released away from edges.
  task automatic do_reset();
    start_a = 0; abort_a = 0; start_b = 0; abort_b = 0;
    #2 rst = 0;
    model_reset();
    #1 check_reset_outputs();
    @(negedge clk);
    #2 rst = 1;
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    ch_in_a = '0; start_a = 0; abort_a = 0; ch_sel_a = '0;
    ch_in_b = '0; start_b = 0; abort_b = 0; ch_sel_b = '0;
    model_reset();
    repeat (3) @(negedge clk);
    #2 check_reset_outputs();
    @(negedge clk);
    #2 rst = 1;
    mon_en = 1;
    tick();

    // basic conversion on ch2, ch_in changed after capture; B converts ch1 then ch3
    ch_in_a = 32'h00A5_0000; start_a = 1; ch_sel_a = 2'd2;
    ch_in_b = {12'h000, 12'hABC, 12'h000}; start_b = 1; ch_sel_b = 2'd1;
    tick();
    start_a = 0; ch_in_a = 32'h0000_0000; start_b = 0;
    tick();
    start_b = 1; ch_sel_b = 2'd3; ch_in_b = {12'hFFF, 12'h123, 12'h456};
    tick();
    start_b = 0;
    // overrun: start while busy is ignored
    start_a = 1; ch_sel_a = 2'd1; ch_in_a = 32'h1122_3344;
    tick();
    start_a = 0;
    ticks(8);
    // next accepted start clears overrun; abort mid-conversion keeps 0xA5
    start_a = 1; ch_sel_a = 2'd0; ch_in_a = 32'h0000_005A;
    tick();
    start_a = 0;
    ticks(4);
    abort_a = 1;
    tick();
    abort_a = 0;
    ticks(10);
    // abort and start together in idle
    start_a = 1; abort_a = 1; start_b = 1; abort_b = 1; ch_sel_b = 2'd0;
    tick();
    start_a = 0; abort_a = 0; start_b = 0; abort_b = 0;
    ticks(10);

    // back-to-back with start held high
    start_a = 1; start_b = 1;
    for (int i = 0; i < 30; i++) begin
      ch_sel_a = 2'($urandom_range(0, 3));
      ch_in_a  = $urandom;
      ch_sel_b = 2'($urandom_range(0, 3));
      ch_in_b  = {4'($urandom), 32'($urandom)};
      tick();
    end
    start_a = 0; start_b = 0;
    ticks(10);

    // reset in the third cycle of a conversion
    start_a = 1; ch_sel_a = 2'd3; ch_in_a = 32'h7700_0000;
    tick();
    start_a = 0;
    ticks(2);
    do_reset();
    ticks(12);

    // randomized traffic including abort collisions
    for (int i = 0; i < 600; i++) begin
      start_a  = ($urandom_range(0, 99) < 35);
      abort_a  = ($urandom_range(0, 99) < 6);
      ch_sel_a = 2'($urandom_range(0, 3));
      ch_in_a  = $urandom;
      start_b  = ($urandom_range(0, 99) < 50);
      abort_b  = ($urandom_range(0, 99) < 10);
      ch_sel_b = 2'($urandom_range(0, 3));
      ch_in_b  = {4'($urandom), 32'($urandom)};
      tick();
    end
    start_a = 0; abort_a = 0; start_b = 0; abort_b = 0;
    ticks(12);

    check("pending_results_a", exp_q_a.size(), 0);
    check("pending_results_b", exp_q_b.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
